stack_arbiter: RTL and testbench
================================

# stack_arbiter

Shares one LIFO stack block (16-bit, depth 16, registered top-of-stack output) between two requesters: requester 0 is the core's call/return path, requester 1 is the interrupt context-save path. The block clears the stack after reset, grants requesters round-robin, and drives the stack's push/pop strobes. It returns popped data, enforces overflow/underflow protection with its own occupancy counter, and acknowledges each operation with a fixed latency.

## Interface
- WIDTH, 16, data width; must match the stack.
- DEPTH, 16, stack depth; must match the stack.
- LEVEL_W, 5, occupancy width; equals log2(DEPTH)+1.
- clock  in  1  rising-edge clock, shared with the stack.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  operation request; held high until the matching ack.
- op0 / op1  in  2  operation: 00 push, 01 pop, 10 peek (only when the macro is defined), 11 reserved.
- wdata0 / wdata1  in  WIDTH  push data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  WIDTH  pop or peek result; valid while ack is high.
- err0 / err1  out  1  operation rejected; valid while ack is high.
- stack_push / stack_pop  out  1  stack strobes.
- stack_data  out  WIDTH  stack write data.
- stack_q  in  WIDTH  current top of stack.
- level  out  LEVEL_W  occupancy counter.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values:
  - state=DRAIN, drain_cnt=0, level=0, last_grant=1.
  - All ack, err and strobe outputs are 0; rdata0/1=0; stack_data=0; busy=1.
- DRAIN state:
  - Drives stack_pop=1 for exactly DEPTH consecutive cycles, then moves to IDLE.
  - Pops issued on an already-empty stack are ignored by the stack.
  - req0/req1 are ignored during DRAIN.
- IDLE state:
  - If any req is high, grant one requester and move to ISSUE.
  - If only one req is high, that requester wins.
  - If both are high, the requester other than last_grant wins.
  - last_grant is updated to the winner.
  - The winner's op and wdata are captured into registers at the grant edge.
- ISSUE state (one cycle), actions by op:
  - push with level<DEPTH: stack_push=1, stack_data=captured wdata, level+1.
  - pop with level>0: stack_pop=1, stack_q sampled into the result register, level−1.
  - peek with level>0: stack_q sampled, no strobe.
  - Full push, empty pop or peek, reserved op, or peek without the macro: no strobe, no level change, error flag set, result=0.
- RESP state (one cycle):
  - ackN=1 for the granted requester only.
  - rdataN and errN are driven from registers.
  - The next state is IDLE.
- stack_push and stack_pop are never high together.
- level never exceeds DEPTH and never wraps below 0.
- A req dropped before its ack does not abort the operation; the ack is still issued.

## Timing
- A req sampled high in IDLE at edge N gives ISSUE in cycle N+1 and RESP/ack in cycle N+2.
- The next grant can happen at the earliest at the edge ending cycle N+3.
- Throughput is one operation per 3 cycles. Latency is fixed for both successful and error operations.
- rdata captures stack_q during the ISSUE cycle. The stack's top register has settled by then because the previous operation completed at least 2 cycles earlier.
- The drain lasts DEPTH cycles after reset_n rises; the first grant can occur in cycle DEPTH.
- Reset asserted mid-operation:
  - All state is cleared immediately and no ack is issued.
  - After release, DRAIN runs in full. Stack contents are discarded.

## Configuration
- STACK_ARB_PEEK_EN:
  - When defined, op 10 reads the top of stack without popping it, with the same latency as pop. Peek on an empty stack returns err=1.
  - When undefined, op 10 is treated as reserved: err=1, no strobe, no level change.

## Test plan
- Reset, then idle: stack_pop is high for cycles 0..15 and busy=1; busy=0 and level=0 from cycle 16.
- req0 push 0x1234, then req0 pop: ack0 at +2 cycles each; pop rdata0=0x1234, err0=0; level goes 1 then 0.
- req0 and req1 both push at the same edge (0xAAAA, 0xBBBB): requester 0 is served first, then requester 1; a subsequent pop returns 0xBBBB.
- 16 pushes then a 17th push: 17th gives err=1, no stack_push pulse, level stays 16. Pop on an empty stack gives err=1 and rdata=0.
- With the macro defined, push 0x00FF, peek, peek: both return 0x00FF and level stays 1. Without the macro, peek gives err=1.
- reset_n pulsed low during ISSUE of a push: no ack is issued, level=0, and a full drain follows.

Source files
------------

// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a 16x16 LIFO: drains the stack after reset,
// guards occupancy, acks every operation two cycles after grant. Define STACK_ARB_PEEK_EN to enable op 10 (peek).
module stack_arbiter #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0,
    input  logic [1:0]         op0,
    input  logic [WIDTH-1:0]   wdata0,
    input  logic               req1,
    input  logic [1:0]         op1,
    input  logic [WIDTH-1:0]   wdata1,
    output logic               ack0,
    output logic [WIDTH-1:0]   rdata0,
    output logic               err0,
    output logic               ack1,
    output logic [WIDTH-1:0]   rdata1,
    output logic               err1,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [WIDTH-1:0]   stack_data,
    input  logic [WIDTH-1:0]   stack_q,
    output logic [LEVEL_W-1:0] level,
    output logic               busy
);

    localparam logic [1:0] S_DRAIN = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

`ifdef STACK_ARB_PEEK_EN
    localparam logic PEEK_EN = 1'b1;
`else
    localparam logic PEEK_EN = 1'b0;
`endif

    logic [1:0]         state;
    logic [LEVEL_W-1:0] drain_cnt;
    logic [LEVEL_W-1:0] level_q;
    logic               last_grant;
    logic               gnt_p0;
    logic [1:0]         op_p0;
    logic [WIDTH-1:0]   wdata_p0;
    logic [WIDTH-1:0]   result_p1;
    logic               err_p1;

    logic               any_req;
    logic               winner;
    logic               issue_ok;
    logic               issue_push;
    logic               issue_pop;
    logic               resp;

    function automatic logic op_accepted(input logic [1:0] op, input logic [LEVEL_W-1:0] lvl);
        case (op)
            OP_PUSH: return lvl < LEVEL_W'(DEPTH);
            OP_POP:  return lvl != '0;
            OP_PEEK: return PEEK_EN && (lvl != '0);
            default: return 1'b0;
        endcase
    endfunction

    assign any_req    = req0 | req1;
    assign winner     = (req0 && req1) ? ~last_grant : req1;
    assign issue_ok   = (state == S_ISSUE) && op_accepted(op_p0, level_q);
    assign issue_push = issue_ok && (op_p0 == OP_PUSH);
    assign issue_pop  = issue_ok && (op_p0 == OP_POP);
    assign resp       = (state == S_RESP);

    // Drain pops are masked while reset is held so the strobe reads 0 during reset.
    assign stack_push = issue_push;
    assign stack_pop  = ((state == S_DRAIN) && reset_n) || issue_pop;
    assign stack_data = wdata_p0;
    assign level      = level_q;
    assign busy       = (state != S_IDLE);

    assign ack0   = resp && !gnt_p0;
    assign ack1   = resp && gnt_p0;
    assign rdata0 = ack0 ? result_p1 : '0;
    assign rdata1 = ack1 ? result_p1 : '0;
    assign err0   = ack0 && err_p1;
    assign err1   = ack1 && err_p1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_DRAIN;
            drain_cnt  <= '0;
            level_q    <= '0;
            last_grant <= 1'b1;
            gnt_p0     <= 1'b0;
            op_p0      <= OP_PUSH;
            wdata_p0   <= '0;
            result_p1  <= '0;
            err_p1     <= 1'b0;
        end else begin
            case (state)
                S_DRAIN: begin
                    if (drain_cnt == LEVEL_W'(DEPTH - 1)) begin
                        drain_cnt <= '0;
                        state     <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + LEVEL_W'(1);
                    end
                end
                // grant stage: capture the winner's request
                S_IDLE: begin
                    if (any_req) begin
                        gnt_p0     <= winner;
                        last_grant <= winner;
                        op_p0      <= winner ? op1 : op0;
                        wdata_p0   <= winner ? wdata1 : wdata0;
                        state      <= S_ISSUE;
                    end
                end
                // issue stage: stack_q is stable here, the previous op finished >= 2 cycles ago
                S_ISSUE: begin
                    if (issue_ok) begin
                        err_p1    <= 1'b0;
                        result_p1 <= (op_p0 == OP_PUSH) ? '0 : stack_q;
                        if (op_p0 == OP_PUSH)
                            level_q <= level_q + LEVEL_W'(1);
                        else if (op_p0 == OP_POP)
                            level_q <= level_q - LEVEL_W'(1);
                    end else begin
                        err_p1    <= 1'b1;
                        result_p1 <= '0;
                    end
                    state <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural registered-top LIFO on the stack side.
module tb_stack_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic        stack_push, stack_pop;
    logic [15:0] stack_data;
    logic [15:0] stack_q;
    logic [4:0]  level;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    stack_arbiter #(.WIDTH(16), .DEPTH(16), .LEVEL_W(5)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .op0(op0), .wdata0(wdata0),
        .req1(req1), .op1(op1), .wdata1(wdata1),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .stack_push(stack_push), .stack_pop(stack_pop), .stack_data(stack_data),
        .stack_q(stack_q), .level(level), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stack block model: pops on empty and pushes on full are ignored, top is registered.
    logic [15:0] mem [0:15];
    logic [4:0]  sp = '0;
    logic [15:0] top_m = '0;
    assign stack_q = top_m;

    always @(posedge clock) begin
        if (stack_push && sp < 5'd16) begin
            mem[sp[3:0]] <= stack_data;
            sp           <= sp + 5'd1;
            top_m        <= stack_data;
        end else if (stack_pop && sp > 5'd0) begin
            sp    <= sp - 5'd1;
            top_m <= (sp >= 5'd2) ? mem[4'(sp - 5'd2)] : 16'h0000;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 64 && busy !== 1'b0; i++) @(negedge clock);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Releases reset at a falling edge and expects exactly 16 drain-pop cycles.
    task automatic check_drain(input string tag);
        int pops;
        logic busy_all;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        pops     = stack_pop ? 1 : 0;
        busy_all = busy;
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            if (stack_pop) pops++;
            busy_all = busy_all & busy;
        end
        check_val({tag, "_drain_pops"}, 32'(pops), 32'd16);
        check_val({tag, "_drain_busy"}, 32'(busy_all), 32'd1);
        @(negedge clock);
        check_val({tag, "_post_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_post_pop"}, 32'(stack_pop), 32'd0);
        check_val({tag, "_post_level"}, 32'(level), 32'd0);
    endtask

    task automatic issue_op(input int who, input logic [1:0] op, input logic [15:0] wd,
                            input logic [15:0] exp_rd, input logic exp_err,
                            input logic exp_push, input logic exp_pop,
                            input logic [4:0] exp_lvl, input string tag);
        wait_idle(tag);
        if (who == 0) begin req0 = 1'b1; op0 = op; wdata0 = wd; end
        else          begin req1 = 1'b1; op1 = op; wdata1 = wd; end
        @(negedge clock);
        check_val({tag, "_issue_ack"}, 32'(ack0 | ack1), 32'd0);
        check_val({tag, "_push"}, 32'(stack_push), 32'(exp_push));
        check_val({tag, "_pop"}, 32'(stack_pop), 32'(exp_pop));
        if (exp_push) check_val({tag, "_sdata"}, 32'(stack_data), 32'(wd));
        @(negedge clock);
        check_val({tag, "_ack"}, 32'(who == 0 ? ack0 : ack1), 32'd1);
        check_val({tag, "_other_ack"}, 32'(who == 0 ? ack1 : ack0), 32'd0);
        check_val({tag, "_rdata"}, 32'(who == 0 ? rdata0 : rdata1), 32'(exp_rd));
        check_val({tag, "_err"}, 32'(who == 0 ? err0 : err1), 32'(exp_err));
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clock);
        check_val({tag, "_level"}, 32'(level), 32'(exp_lvl));
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clock);
        check_val("rst_busy", 32'(busy), 32'd1);
        check_val("rst_pop", 32'(stack_pop), 32'd0);
        check_val("rst_push", 32'(stack_push), 32'd0);
        check_val("rst_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
        check_val("rst_rdata", 32'(rdata0 | rdata1), 32'd0);
        check_val("rst_sdata", 32'(stack_data), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_drain("boot");

        // Simultaneous pushes: requester 0 wins first after reset, requester 1 follows.
        req0 = 1'b1; op0 = 2'b00; wdata0 = 16'hAAAA;
        req1 = 1'b1; op1 = 2'b00; wdata1 = 16'hBBBB;
        @(negedge clock);
        check_val("dual0_sdata", 32'(stack_data), 32'h0000AAAA);
        check_val("dual0_push", 32'(stack_push), 32'd1);
        @(negedge clock);
        check_val("dual0_ack", 32'({ack0, ack1}), 32'b10);
        check_val("dual0_err", 32'(err0), 32'd0);
        req0 = 1'b0;
        @(negedge clock);
        check_val("dual_gap_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check_val("dual1_sdata", 32'(stack_data), 32'h0000BBBB);
        check_val("dual1_push", 32'(stack_push), 32'd1);
        @(negedge clock);
        check_val("dual1_ack", 32'({ack0, ack1}), 32'b01);
        req1 = 1'b0;
        @(negedge clock);
        check_val("dual_level", 32'(level), 32'd2);
        issue_op(0, 2'b01, 16'h0, 16'hBBBB, 1'b0, 1'b0, 1'b1, 5'd1, "pop_bb");
        issue_op(1, 2'b01, 16'h0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 5'd0, "pop_aa");

        issue_op(0, 2'b00, 16'h1234, 16'h0, 1'b0, 1'b1, 1'b0, 5'd1, "push_1234");
        issue_op(0, 2'b01, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b1, 5'd0, "pop_1234");

        // Fill to the limit, overflow, empty out, underflow.
        for (int i = 0; i < 16; i++)
            issue_op(i % 2, 2'b00, 16'h1000 + 16'(i), 16'h0, 1'b0, 1'b1, 1'b0, 5'(i + 1), "fill");
        issue_op(0, 2'b00, 16'hDEAD, 16'h0, 1'b1, 1'b0, 1'b0, 5'd16, "overflow");
        for (int i = 15; i >= 0; i--)
            issue_op(1, 2'b01, 16'h0, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b1, 5'(i), "drainout");
        issue_op(0, 2'b01, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd0, "underflow");

        issue_op(0, 2'b00, 16'h00FF, 16'h0, 1'b0, 1'b1, 1'b0, 5'd1, "push_ff");
`ifdef STACK_ARB_PEEK_EN
        issue_op(0, 2'b10, 16'h0, 16'h00FF, 1'b0, 1'b0, 1'b0, 5'd1, "peek_a");
        issue_op(1, 2'b10, 16'h0, 16'h00FF, 1'b0, 1'b0, 1'b0, 5'd1, "peek_b");
`else
        issue_op(0, 2'b10, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd1, "peek_off");
`endif
        issue_op(1, 2'b11, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd1, "reserved");
        issue_op(0, 2'b01, 16'h0, 16'h00FF, 1'b0, 1'b0, 1'b1, 5'd0, "pop_ff");

        // Reset arriving in the ISSUE cycle of a push cancels it without an ack.
        issue_op(0, 2'b00, 16'h7777, 16'h0, 1'b0, 1'b1, 1'b0, 5'd1, "push_77");
        wait_idle("rst_mid");
        req0 = 1'b1; op0 = 2'b00; wdata0 = 16'h5555;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("mid_push", 32'(stack_push), 32'd0);
        check_val("mid_level", 32'(level), 32'd0);
        check_val("mid_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check_val("mid_no_ack", 32'({ack0, ack1}), 32'd0);
        end
        check_drain("rearm");
        issue_op(0, 2'b01, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd0, "post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
